// File: rtl/pipelined_carry_adder.sv
// Pipelined ripple-carry adder/subtractor: the carry chain is cut into STAGES
// slices, each registering its partial sum and carry, with a global valid/ready stall.
module pipelined_carry_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sout,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             advance;
  logic [WIDTH-1:0] b_fold;
  logic             c0;

  // Subtraction becomes A + ~B + ~Cin, so every stage is a plain adder
  assign b_fold   = Sub ? ~B : B;
  assign c0       = Sub ^ Cin;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int HI   = (k + 1) * CHUNK;
    localparam int SRCW = WIDTH - k * CHUNK;

    logic [SRCW-1:0]  a_src;
    logic [SRCW-1:0]  b_src;
    logic             c_in;
    logic             v_in;
    logic [CHUNK:0]   slice_sum;
    logic [HI-1:0]    sum_d;
    logic [HI-1:0]    sum_q;
    logic             vld_q;
    logic             cry_q;

    if (k == 0) begin : g_head
      assign a_src = A;
      assign b_src = b_fold;
      assign c_in  = c0;
      assign v_in  = in_valid;
      assign sum_d = slice_sum[CHUNK-1:0];
    end else begin : g_body
      // Operand slice comes off the bottom of the previous stage's skew register
      assign a_src = g_stage[k-1].g_skew.a_rem;
      assign b_src = g_stage[k-1].g_skew.b_rem;
      assign c_in  = g_stage[k-1].cry_q;
      assign v_in  = g_stage[k-1].vld_q;
      assign sum_d = {slice_sum[CHUNK-1:0], g_stage[k-1].sum_q};
    end

    assign slice_sum = {1'b0, a_src[CHUNK-1:0]} + {1'b0, b_src[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, c_in};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cry_q <= 1'b0;
        sum_q <= '0;
      end else if (advance) begin
        vld_q <= v_in;
        cry_q <= slice_sum[CHUNK];
        sum_q <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [SRCW-CHUNK-1:0] a_rem;
      logic [SRCW-CHUNK-1:0] b_rem;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem <= '0;
          b_rem <= '0;
        end else if (advance) begin
          a_rem <= a_src[SRCW-1:CHUNK];
          b_rem <= b_src[SRCW-1:CHUNK];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      // Carry into the MSB is recovered as a^b^sum of that bit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= a_src[CHUNK-1] ^ b_src[CHUNK-1] ^ slice_sum[CHUNK-1] ^ slice_sum[CHUNK];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign Sout      = g_stage[STAGES-1].sum_q;
  assign Cout      = g_stage[STAGES-1].cry_q;
  assign Ovf       = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Directed and randomised checks of pipelined_carry_adder: a 16/4 instance for
// directed, streaming and reset tests, plus a sweep of other WIDTH/STAGES pairs.
module tb_pipelined_carry_adder;

  localparam int NSW = 4;

  function automatic int swWidth(input int i);
    case (i)
      0:       return 4;
      1:       return 8;
      2:       return 32;
      default: return 64;
    endcase
  endfunction

  function automatic int swStages(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 8;
      default: return 4;
    endcase
  endfunction

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sout;
  logic        cout;
  logic        ovf;

  logic [63:0]    sw_a;
  logic [63:0]    sw_b;
  logic           sw_cin;
  logic           sw_sub;
  logic [NSW-1:0] sw_ivalid;
  logic [NSW-1:0] sw_iready;
  logic [NSW-1:0] sw_ovalid;
  logic [NSW-1:0] sw_oready;
  logic [NSW-1:0] sw_cout;
  logic [NSW-1:0] sw_ovf;
  logic [63:0]    sw_sout [NSW];

  int tests = 0;
  int fails = 0;

  logic [15:0] qa [20];
  logic [15:0] qb [20];
  logic        qc [20];
  logic        qs [20];

  int             acc [NSW];
  logic [65:0]    sq [NSW][$];
  logic [NSW-1:0] prev_stall;
  logic [65:0]    prev_o [NSW];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipelined_carry_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .Sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sout(sout), .Cout(cout), .Ovf(ovf)
  );

  for (genvar i = 0; i < NSW; i++) begin : g_sweep
    localparam int W = swWidth(i);
    localparam int S = swStages(i);
    logic [W-1:0] so;

    pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_ivalid[i]), .in_ready(sw_iready[i]),
      .A(sw_a[W-1:0]), .B(sw_b[W-1:0]), .Cin(sw_cin), .Sub(sw_sub),
      .out_valid(sw_ovalid[i]), .out_ready(sw_oready[i]),
      .Sout(so), .Cout(sw_cout[i]), .Ovf(sw_ovf[i])
    );
    assign sw_sout[i] = 64'(so);
  end

  // Reference: {ovf, cout, sum} from wide arithmetic and operand/result signs
  function automatic logic [65:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                        input logic ci, input logic sb);
    logic [64:0] full;
    logic [63:0] mask;
    logic [63:0] xm;
    logic [63:0] ym;
    logic [63:0] s;
    logic        co;
    logic        ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    xm   = x & mask;
    ym   = (sb ? ~y : y) & mask;
    full = {1'b0, xm} + {1'b0, ym} + {64'd0, ci ^ sb};
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (xm[w-1] == ym[w-1]) && (s[w-1] != xm[w-1]);
    return {ov, co, s};
  endfunction

  task automatic checkOutput(input string tag, input logic [65:0] obs, input logic [65:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                               input logic vc, input logic vs);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    cin      = vc;
    sub      = vs;
    checkOutput("accept_ready", 66'(in_ready), 66'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic runDirected(input string tag, input logic [15:0] va, input logic [15:0] vb,
                             input logic vc, input logic vs,
                             input logic [15:0] es, input logic ec, input logic eo);
    applyStimulus(va, vb, vc, vs);
    repeat (2) @(posedge clk);
    #1;
    checkOutput({tag, "_early"}, 66'(out_valid), 66'(0));
    @(posedge clk);
    #1;
    checkOutput({tag, "_result"}, 66'({out_valid, ovf, cout, sout}), 66'({1'b1, eo, ec, es}));
    @(posedge clk);
    #1;
  endtask

  task automatic sweepCheck(input int i);
    logic [65:0] o;
    int          w;
    w = swWidth(i);
    o = {sw_ovf[i], sw_cout[i], sw_sout[i]};
    checkOutput($sformatf("sweep%0d_in_ready", i), 66'(sw_iready[i]),
                66'(!(sw_ovalid[i] && !sw_oready[i])));
    if (prev_stall[i])
      checkOutput($sformatf("sweep%0d_hold", i), {sw_ovalid[i], o[64:0]}, {1'b1, prev_o[i][64:0]});
    if (sw_ovalid[i] && sw_oready[i]) begin
      if (sq[i].size() == 0)
        checkOutput($sformatf("sweep%0d_spurious", i), 66'(sq[i].size() != 0), 66'(1));
      else
        checkOutput($sformatf("sweep%0d_beat", i), o, sq[i].pop_front());
    end
    prev_stall[i] = sw_ovalid[i] && !sw_oready[i];
    prev_o[i]     = o;
    if (sw_ivalid[i] && sw_iready[i]) begin
      sq[i].push_back(model(w, sw_a, sw_b, sw_cin, sw_sub));
      acc[i]++;
    end
  endtask

  initial begin
    int          sent;
    int          recv;
    int          stale;
    logic        stalled_prev;
    logic [18:0] prev_out;
    logic [65:0] m;
    logic        all_done;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    sw_a      = '0;
    sw_b      = '0;
    sw_cin    = 1'b0;
    sw_sub    = 1'b0;
    sw_ivalid = '0;
    sw_oready = '0;
    prev_stall = '0;
    for (int i = 0; i < NSW; i++) begin
      acc[i]    = 0;
      prev_o[i] = '0;
    end

    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_outputs", 66'({out_valid, ovf, cout, sout}), 66'(0));
    checkOutput("reset_in_ready", 66'(in_ready), 66'(1));
    repeat (2) @(posedge clk);
    #3;
    checkOutput("reset_held", 66'({out_valid, ovf, cout, sout}), 66'(0));
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    runDirected("add_ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    runDirected("sub_borrow",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    runDirected("sub_noborrow", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
    runDirected("add_ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    runDirected("sub_ovf",      16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    runDirected("add_cin",      16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    runDirected("add_negovf",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    runDirected("sub_borrowin", 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);

    $display("[TB] streaming with a 3-cycle stall");
    for (int i = 0; i < 20; i++) begin
      qa[i] = 16'($urandom);
      qb[i] = 16'($urandom);
      qc[i] = 1'($urandom_range(0, 1));
      qs[i] = 1'($urandom_range(0, 1));
    end
    sent         = 0;
    recv         = 0;
    stalled_prev = 1'b0;
    prev_out     = '0;
    for (int cyc = 0; cyc < 80 && recv < 20; cyc++) begin
      in_valid = (sent < 20);
      if (sent < 20) begin
        a   = qa[sent];
        b   = qb[sent];
        cin = qc[sent];
        sub = qs[sent];
      end
      out_ready = !(cyc >= 8 && cyc < 11);
      @(negedge clk);
      checkOutput("stream_in_ready", 66'(in_ready), 66'(!(out_valid && !out_ready)));
      if (stalled_prev)
        checkOutput("stream_hold", 66'({out_valid, ovf, cout, sout}), 66'(prev_out));
      if (out_valid && out_ready) begin
        m = model(16, 64'(qa[recv]), 64'(qb[recv]), qc[recv], qs[recv]);
        checkOutput($sformatf("stream_beat%0d", recv), 66'({ovf, cout, sout}), 66'({m[65:64], m[15:0]}));
        recv++;
      end
      stalled_prev = out_valid && !out_ready;
      prev_out     = {out_valid, ovf, cout, sout};
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream_count", 66'(recv), 66'(20));

    $display("[TB] reset with beats in flight");
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a        = 16'h1111 * 16'(i + 1);
      b        = 16'h2222;
      cin      = 1'b0;
      sub      = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("pre_reset_beat", 66'({out_valid, sout}), 66'({1'b1, 16'h3333}));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_flush", 66'({out_valid, ovf, cout, sout}), 66'(0));
    checkOutput("reset_flush_ready", 66'(in_ready), 66'(1));
    @(posedge clk);
    #3 rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checkOutput("no_stale_beat", 66'(stale), 66'(0));
    @(posedge clk);
    #1;
    runDirected("post_reset", 16'h00F0, 16'h0F0F, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0);

    $display("[TB] parameter sweep");
    for (int cyc = 0; cyc < 6000; cyc++) begin
      all_done = 1'b1;
      for (int i = 0; i < NSW; i++) if (acc[i] < 1000) all_done = 1'b0;
      if (all_done) break;
      sw_a   = {$urandom, $urandom};
      sw_b   = {$urandom, $urandom};
      sw_cin = 1'($urandom_range(0, 1));
      sw_sub = 1'($urandom_range(0, 1));
      for (int i = 0; i < NSW; i++) begin
        sw_ivalid[i] = (acc[i] < 1000) && ($urandom_range(0, 3) != 0);
        sw_oready[i] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      for (int i = 0; i < NSW; i++) sweepCheck(i);
      @(posedge clk);
      #1;
    end
    sw_ivalid = '0;
    sw_oready = '1;
    repeat (12) begin
      @(negedge clk);
      for (int i = 0; i < NSW; i++) sweepCheck(i);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < NSW; i++) begin
      checkOutput($sformatf("sweep%0d_accepted", i), 66'(acc[i]), 66'(1000));
      checkOutput($sformatf("sweep%0d_drained", i), 66'(sq[i].size()), 66'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_carry_adder.md
# pipelined_carry_adder

Parametrised, pipelined ripple-carry adder/subtractor. Splits a WIDTH-bit carry chain into STAGES equal slices, each with a registered carry, so wide operands close timing at full clock rate. Accepts one operation per cycle through a valid/ready handshake and returns results in order after a fixed latency. It sits in the datapath wherever the 4-bit combinational adder no longer meets width or frequency requirements.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of STAGES
- STAGES, 4, pipeline depth and number of carry slices; 1..WIDTH; CHUNK = WIDTH/STAGES
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in (add) / borrow-in (sub)
- Sub  input  1  0: Sout = A+B+Cin; 1: Sout = A-B-Cin
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- Sout  output  WIDTH  sum/difference, modulo 2^WIDTH
- Cout  output  1  add: carry-out; sub: 1 = no borrow, 0 = borrow
- Ovf  output  1  two's-complement signed overflow

## Operation
- Sub folded at input: B' = Sub ? ~B : B; c0 = Sub ? ~Cin : Cin. Stage 0 then computes A + B' + c0 identically for both modes.
- Stage k (0..STAGES-1) adds slice [k*CHUNK +: CHUNK] of A and B' plus the carry registered by stage k-1 (c0 for stage 0). It registers its sum slice and carry-out.
- Unprocessed upper slices of A/B' travel forward in skew registers. Completed lower sum slices travel forward in deskew registers. All slices of one beat emerge together.
- Ovf = carry into MSB XOR carry out of MSB; computed in the last stage.
- Each stage holds a valid bit. Global advance = !out_valid || out_ready. in_ready = advance.
- On advance: every stage loads from its predecessor, including valid. Stage 0 loads the input beat, with valid = in_valid. When in_valid = 0, a bubble (valid 0) enters.
- When advance = 0: all stages hold. Output data and valid stay stable while out_valid && !out_ready.
- Outputs are driven directly from the last stage registers: Sout, Cout, Ovf, out_valid.
- A beat transfers in when in_valid && in_ready. It transfers out when out_valid && out_ready.
- Result ordering is strictly FIFO. No beat is dropped or duplicated.

## Timing
- Reset (rst_n low, asynchronous): all valid bits = 0, all data/carry registers = 0. out_valid = 0, Sout = 0, Cout = 0, Ovf = 0, in_ready = 1.
- Reset asserted mid-operation discards every in-flight beat immediately.
- After rst_n deasserts, the first accepting edge is the next rising edge.
- Latency: a beat accepted at edge N is presented with out_valid = 1 after edge N+STAGES-1 (stage registers count as STAGES cycles, with the output on the final stage register). It is visible during cycle N+STAGES-1.
- Throughput: 1 beat/cycle while out_ready = 1.
- in_ready is combinational from out_valid and out_ready. No combinational path exists from in_valid, A, or B to any output.
- Simultaneous output accept and input accept in the same cycle is legal and required (full pipeline, no bubble).
- Bubbles in the pipe do not by themselves deassert in_ready. Only a held last-stage result does.
- STAGES = 1 degenerates to a single registered adder with latency 1.

## Test plan
- Add carry ripple across all slices: WIDTH=16, STAGES=4, A=0xFFFF, B=0x0001, Cin=0, Sub=0 -> 4 cycles later Sout=0x0000, Cout=1, Ovf=0.
- Subtract with borrow: A=0x0005, B=0x0007, Cin=0, Sub=1 -> Sout=0xFFFE, Cout=0, Ovf=0. Then A=0x0007, B=0x0005, Cin=1, Sub=1 -> Sout=0x0001, Cout=1.
- Signed overflow: A=0x7FFF, B=0x0001, add -> Sout=0x8000, Ovf=1, Cout=0. Also A=0x8000, B=0x0001, Sub=1 -> Sout=0x7FFF, Ovf=1.
- Streaming and backpressure: 20 back-to-back random beats with out_ready low for 3 cycles mid-stream. Required: in_ready low exactly while out_valid && !out_ready, outputs stable while stalled, all 20 results match the reference model in order, 1 beat/cycle otherwise.
- Reset mid-stream: rst_n pulsed low with 3 beats in flight -> out_valid=0 and Sout=0 immediately. No stale beat appears after release. A new beat afterwards returns with latency 4.
- Parameter sweep: (WIDTH, STAGES) = (4,1), (8,2), (32,8), (64,4). 1000 random beats each, random Sub/Cin/out_ready -> zero mismatches against a behavioural model.
